// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer: each accepted word lands in a one-entry
// holding register on the channel named by in_sel, and every channel counts its deliveries.
module stream_demux_1_4 #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [W-1:0]     in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [4*W-1:0]   out_data,
   output logic [4*CNT_W-1:0] out_cnt
);

   logic [3:0]       valid_q, valid_d;
   logic [W-1:0]     data_q [4];
   logic [W-1:0]     data_d [4];
   logic [CNT_W-1:0] cnt_q  [4];
   logic [CNT_W-1:0] cnt_d  [4];

   logic       accept;
   logic [3:0] drain;
   logic [3:0] fill;

   // A channel can take a new word when it is empty or is being emptied this same cycle.
   always_comb begin
      in_ready = !rst && (!valid_q[in_sel] || out_ready[in_sel]);
      accept   = in_valid && in_ready;
   end

   always_comb begin
      drain   = valid_q & out_ready;
      fill    = 4'b0000;
      valid_d = valid_q;
      for (int k = 0; k < 4; k++) begin
         data_d[k] = data_q[k];
         cnt_d[k]  = cnt_q[k] + CNT_W'(drain[k]);
         fill[k]   = accept && (in_sel == 2'(k));
         valid_d[k] = fill[k] || (valid_q[k] && !drain[k]);
         if (fill[k]) begin
            data_d[k] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= data_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
      end
   end

   always_comb begin
      out_valid = valid_q;
      out_data  = '0;
      out_cnt   = '0;
      for (int k = 0; k < 4; k++) begin
         out_data[k*W +: W]         = data_q[k];
         out_cnt[k*CNT_W +: CNT_W]  = cnt_q[k];
      end
   end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed scenarios plus random traffic, all checked
// against a per-channel queue model with modulo delivery counts.
module tb_stream_demux_1_4;

   localparam int W     = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [W-1:0]     in_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [4*W-1:0]   out_data;
   logic [4*CNT_W-1:0] out_cnt;

   int total = 0;
   int bad   = 0;

   // Reference: each channel is a queue of at most one word, plus the last word written
   // (what the output shows once drained) and a plain integer delivery count.
   logic [W-1:0] chanQ [4][$];
   logic [W-1:0] lastWord [4];
   int           delivered [4];

   stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sel(in_sel),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_cnt(out_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare the DUT against the model, then advance the model.
   task automatic applyStimulus(input logic r, input logic v, input logic [1:0] sel,
                                input logic [W-1:0] d, input logic [3:0] ordy);
      logic expReady;
      logic [3:0] expValid;
      @(negedge clk);
      rst = r; in_valid = v; in_sel = sel; in_data = d; out_ready = ordy;
      #1;
      expReady = !r && (chanQ[sel].size() == 0 || ordy[sel]);
      for (int k = 0; k < 4; k++) expValid[k] = (chanQ[k].size() != 0);
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]),
                     32'((chanQ[k].size() != 0) ? chanQ[k][0] : lastWord[k]));
         checkOutput($sformatf("out_cnt[%0d]", k), 32'(out_cnt[k*CNT_W +: CNT_W]),
                     32'(delivered[k] % 256));
      end
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            chanQ[k].delete();
            lastWord[k] = '0;
            delivered[k] = 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (chanQ[k].size() != 0 && ordy[k]) begin
               void'(chanQ[k].pop_front());
               delivered[k]++;
            end
         end
         if (v && expReady) begin
            chanQ[sel].push_back(d);
            lastWord[sel] = d;
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'h0;
      for (int k = 0; k < 4; k++) begin
         lastWord[k] = '0;
         delivered[k] = 0;
      end

      // Reset held with traffic present
      applyStimulus(1, 1, 2'd1, 4'h9, 4'hF);
      applyStimulus(1, 1, 2'd2, 4'h6, 4'hF);
      applyStimulus(1, 1, 2'd3, 4'h6, 4'hF);
      checkOutput("reset cnt ch0", 32'(out_cnt[0 +: CNT_W]), 32'd0);

      // Routing to every channel
      applyStimulus(0, 1, 2'd0, 4'ha, 4'hF);
      applyStimulus(0, 1, 2'd1, 4'hb, 4'hF);
      applyStimulus(0, 1, 2'd2, 4'hc, 4'hF);
      applyStimulus(0, 1, 2'd3, 4'hd, 4'hF);
      applyStimulus(0, 0, 2'd0, 4'h0, 4'hF);
      applyStimulus(0, 0, 2'd0, 4'h0, 4'hF);

      // Backpressure isolation on ch2
      applyStimulus(0, 1, 2'd2, 4'h3, 4'hB);
      applyStimulus(0, 1, 2'd2, 4'h7, 4'hB);
      applyStimulus(0, 1, 2'd2, 4'h7, 4'hB);
      applyStimulus(0, 1, 2'd1, 4'h5, 4'hB);
      applyStimulus(0, 0, 2'd1, 4'h0, 4'hB);
      applyStimulus(0, 1, 2'd2, 4'h7, 4'hF);
      applyStimulus(0, 0, 2'd2, 4'h0, 4'hF);
      applyStimulus(0, 0, 2'd2, 4'h0, 4'hF);

      // Same-cycle drain and fill on ch0
      applyStimulus(0, 1, 2'd0, 4'h1, 4'h0);
      applyStimulus(0, 1, 2'd0, 4'h2, 4'h1);
      applyStimulus(0, 1, 2'd0, 4'h3, 4'h1);
      applyStimulus(0, 1, 2'd0, 4'h4, 4'h1);
      applyStimulus(0, 0, 2'd0, 4'h0, 4'h1);
      applyStimulus(0, 0, 2'd0, 4'h0, 4'h1);

      // Counter wrap on ch3
      for (int i = 0; i < 262; i++) applyStimulus(0, 1, 2'd3, 4'(i), 4'h8);
      applyStimulus(0, 0, 2'd3, 4'h0, 4'h8);

      // Mid-operation reset with ch1 and ch2 full
      applyStimulus(0, 1, 2'd1, 4'he, 4'h0);
      applyStimulus(0, 1, 2'd2, 4'hf, 4'h0);
      applyStimulus(1, 1, 2'd0, 4'h1, 4'hF);
      applyStimulus(0, 1, 2'd0, 4'h2, 4'hF);
      applyStimulus(0, 0, 2'd0, 4'h0, 4'hF);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                       2'($urandom_range(0, 3)), 4'($urandom),
                       4'($urandom) | 4'($urandom));
      end
      applyStimulus(0, 0, 2'd0, 4'h0, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Registered 1-to-4 stream demultiplexer with valid/ready handshakes; the receiving counterpart of the team's 4:1 data mux.
- Routes each accepted input word to one of four output channels selected by a 2-bit select that travels with the word.
- Each output channel has a one-entry holding register and an 8-bit delivered-word counter, so a stalled channel never blocks the other channels.

Parameters:
- W, 4, data width of input and each output channel.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_sel  input  2  target channel for the input word; qualified by in_valid.
- in_data  input  W  input word.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- out_data  output  4*W  channel k word in bits [k*W +: W].
- out_cnt  output  4*CNT_W  channel k delivered count in bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (synchronous; rst sampled high at a clk edge):
  - out_valid = 0, out_data = 0, out_cnt = 0.
  - in_ready is forced to 0 combinationally while rst is high.
  - Reset mid-operation discards held words and clears counters; no handshake completes in a cycle where rst is high.
- Input acceptance:
  - in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]), purely combinational.
  - in_ready must not depend on in_valid.
  - Accept occurs when in_valid && in_ready at a clk edge.
- Fill:
  - On accept, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency 1: the word is visible at the output on the cycle after the accept.
  - Data is passed bit-exact, including X bits.
- Drain:
  - Channel k handshakes when out_valid[k] && out_ready[k].
  - If not refilled in the same cycle, out_valid[k] <= 0.
  - out_data[k] holds its last value after the drain; only out_valid qualifies it.
- Simultaneous drain and fill of the same channel:
  - Accepted, because in_ready is high via out_ready.
  - out_valid[k] stays 1 and out_data[k] takes the new word. Full throughput of 1 word/cycle per channel.
- Channels are independent:
  - A full, stalled channel deasserts in_ready only while in_sel points at it.
  - Words aimed at other channels proceed normally.
- Stability rule:
  - Once out_valid[k] is high, out_data[k] must not change until the handshake on channel k.
  - out_ready[k] while out_valid[k] = 0 has no effect.
- Counters:
  - out_cnt[k] increments by 1 on each channel-k output handshake.
  - Wraps from 2^CNT_W-1 to 0 with no saturation or flag.
  - Multiple channels may increment in the same cycle.
- No internal state machine beyond per-channel full/empty flags; no combinational path from in_data to out_data.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and out_ready=4'hF.
  -> in_ready=0, out_valid=4'h0, out_data all 0, out_cnt all 0.
- Routing: out_ready=4'hF; send (sel,data) = (0,'ha),(1,'hb),(2,'hc),(3,'hd) on consecutive cycles.
  -> each word appears 1 cycle after accept on its channel only.
  -> each channel's out_valid pulses exactly one cycle.
  -> out_cnt = 1,1,1,1.
- Backpressure isolation: out_ready[2]=0; send (2,'h3),(2,'h7),(1,'h5).
  -> 'h3 held on ch2; in_ready=0 while sel=2.
  -> once the bench switches to sel=1, 'h5 is delivered on ch1; ch2 still shows 'h3.
  -> raise out_ready[2]: 'h3 drains, then 'h7 is accepted and delivered.
- Same-cycle drain/fill: ch0 full with 'h1 and out_ready[0]=1; stream 'h2,'h3,'h4 to sel=0 back-to-back.
  -> in_ready stays 1 and out_valid[0] stays 1.
  -> out_data[0] reads 1,2,3,4 on successive cycles; out_cnt[0] = 4.
- Counter wrap: deliver 256 words on ch3.
  -> out_cnt[3] = 0 after word 256, 255 after word 255.
  -> other counters unchanged.
- Mid-operation reset: ch1 and ch2 full, assert rst one cycle with out_ready=4'hF.
  -> out_valid=0 and counters=0 next cycle; no count increments in the reset cycle.
  -> normal operation resumes the cycle after rst falls.
